// File: rtl/usb4_clk_pkg.sv
// Shared types and constants for the USB4 clock-enable generator and reset sequencer.
// Default phase increments assume ACC_W=32 and an 80 GHz local_clk.
package usb4_clk_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  // inc = rate / 80 GHz * 2**32
  localparam logic [31:0] GEN2_INC = 32'h2000_0000;
  localparam logic [31:0] GEN3_INC = 32'h4000_0000;
  localparam logic [31:0] GEN4_INC = 32'h8000_0000;
  localparam logic [31:0] SB_INC   = 32'h0000_D1B7;

  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb4_nco_ch.sv
// One fractional phase accumulator producing a registered carry tick.
// With USB4_PHASE_OUT_EN defined it also produces a divide-by-two phase output.
module usb4_nco_ch #(
  parameter int ACC_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [ACC_W-1:0] i_inc,
  output logic             o_tick
`ifdef USB4_PHASE_OUT_EN
  ,
  output logic             o_phase
`endif
);

  logic [ACC_W-1:0] r_acc;
  logic             r_tick;
  logic [ACC_W:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, i_inc};
  assign o_tick = r_tick;

  // Clearing takes priority so a disabled channel restarts from phase zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= {ACC_W{1'b0}};
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_acc  <= {ACC_W{1'b0}};
      r_tick <= 1'b0;
    end else if (i_en) begin
      r_acc  <= w_sum[ACC_W-1:0];
      r_tick <= w_sum[ACC_W];
    end else begin
      r_tick <= 1'b0;
    end
  end

`ifdef USB4_PHASE_OUT_EN
  logic r_phase;

  assign o_phase = r_phase;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= r_phase ^ w_sum[ACC_W];
    end
  end
`endif

endmodule

// File: rtl/usb4_clk_rst_seq.sv
// USB4 multi-channel NCO tick generator with a sideband-paced reset release sequencer.
// Optional divided phase outputs are enabled by defining USB4_PHASE_OUT_EN.
module usb4_clk_rst_seq
  import usb4_clk_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int ACC_W      = 32,
  parameter int RST_CYCLES = 3,
  parameter int SB_CH      = 0,
  parameter int CNT_W      = 8
) (
  input  logic                          local_clk,
  input  logic                          rst,
  input  logic                          sw_rst,
  input  logic                          cfg_we,
  input  logic [CH_IDX_W(NUM_CH)-1:0]   cfg_ch,
  input  logic                          cfg_en,
  input  logic [ACC_W-1:0]              cfg_inc,
  output logic [NUM_CH-1:0]             tick_o,
  output logic [NUM_CH-1:0]             rst_n_o,
  output logic                          ready_o
`ifdef USB4_PHASE_OUT_EN
  ,
  output logic [NUM_CH-1:0]             phase_o
`endif
);

  localparam int                CW       = CH_IDX_W(NUM_CH);
  localparam logic [CW:0]       NUM_CH_L = (CW + 1)'(NUM_CH);
  localparam logic [CW-1:0]     IDX_LAST = CW'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RST_CYCLES - 1);

  logic [ACC_W-1:0]  r_inc [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_tick;
  logic              w_ch_ok;
  logic              w_sb_tick;

  seq_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CW-1:0]     r_idx;
  logic [NUM_CH-1:0] r_rst_n;
  logic              r_ready;

  assign w_ch_ok   = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);
  assign w_sb_tick = w_tick[SB_CH];
  assign tick_o    = w_tick;
  assign rst_n_o   = r_rst_n;
  assign ready_o   = r_ready;

  // Channel configuration registers; out-of-range channel writes are dropped.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_inc[i] <= {ACC_W{1'b0}};
      end
      r_en <= {NUM_CH{1'b0}};
    end else if (w_ch_ok) begin
      r_inc[cfg_ch] <= cfg_inc;
      r_en[cfg_ch]  <= cfg_en;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CW-1:0] CH_ID = CW'(g);

    assign w_clr[g] = w_ch_ok && (cfg_ch == CH_ID) && !cfg_en;

    usb4_nco_ch #(
      .ACC_W (ACC_W)
    ) u_nco (
      .i_clk   (local_clk),
      .i_rst_n (rst),
      .i_en    (r_en[g]),
      .i_clr   (w_clr[g]),
      .i_inc   (r_inc[g]),
      .o_tick  (w_tick[g])
`ifdef USB4_PHASE_OUT_EN
      ,
      .o_phase (phase_o[g])
`endif
    );
  end

  // Reset sequencer: hold for RST_CYCLES sideband ticks, then release one channel per tick.
  always_ff @(posedge local_clk or negedge rst) begin
    if (!rst) begin
      r_state <= HOLD;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {CW{1'b0}};
      r_rst_n <= {NUM_CH{1'b0}};
      r_ready <= 1'b0;
    end else if (sw_rst) begin
      r_state <= HOLD;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {CW{1'b0}};
      r_rst_n <= {NUM_CH{1'b0}};
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          r_rst_n <= {NUM_CH{1'b0}};
          r_ready <= 1'b0;
          if (w_sb_tick) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == CNT_LAST) begin
              r_state <= RELEASE;
              r_idx   <= {CW{1'b0}};
            end
          end
        end
        RELEASE: begin
          r_ready <= 1'b0;
          if (w_sb_tick) begin
            r_rst_n[r_idx] <= 1'b1;
            if (r_idx == IDX_LAST) begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end else begin
              r_idx <= r_idx + {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        RUN: begin
          r_rst_n <= {NUM_CH{1'b1}};
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= HOLD;
          r_cnt   <= {CNT_W{1'b0}};
          r_idx   <= {CW{1'b0}};
          r_rst_n <= {NUM_CH{1'b0}};
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb4_clk_rst_seq.sv
// Directed + randomized bench for usb4_clk_rst_seq against a cycle-level reference model.
module tb_usb4_clk_rst_seq;

  localparam int NCH = 4;
  localparam int RC  = 3;

  logic        local_clk = 1'b0;
  logic        rst       = 1'b0;
  logic        sw_rst    = 1'b0;
  logic        cfg_we    = 1'b0;
  logic [1:0]  cfg_ch    = 2'd0;
  logic        cfg_en    = 1'b0;
  logic [31:0] cfg_inc   = 32'd0;
  logic [3:0]  tick_o;
  logic [3:0]  rst_n_o;
  logic        ready_o;
`ifdef USB4_PHASE_OUT_EN
  logic [3:0]  phase_o;
`endif

  usb4_clk_rst_seq dut (
    .local_clk (local_clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_en    (cfg_en),
    .cfg_inc   (cfg_inc),
    .tick_o    (tick_o),
    .rst_n_o   (rst_n_o),
    .ready_o   (ready_o)
`ifdef USB4_PHASE_OUT_EN
    ,
    .phase_o   (phase_o)
`endif
  );

  always #5 local_clk = ~local_clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accumulators as wide integers, sequencer as a count of SB ticks.
  longint unsigned m_acc [NCH];
  logic [31:0]     m_inc [NCH];
  bit              m_en  [NCH];
  bit              m_tick[NCH];
  bit              m_ph  [NCH];
  int              m_sb;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_inc[i] = 32'd0; m_en[i] = 1'b0; m_tick[i] = 1'b0; m_ph[i] = 1'b0;
    end
    m_sb = 0;
  endfunction

  function automatic void model_edge();
    bit sb_prev;
    longint unsigned s;
    sb_prev = m_tick[0];
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit sel;
      sel = cfg_we && (int'(cfg_ch) == c);
      if (sel && !cfg_en) begin
        m_acc[c] = 0; m_tick[c] = 1'b0; m_ph[c] = 1'b0;
      end else if (m_en[c]) begin
        s = m_acc[c] + longint'(m_inc[c]);
        m_tick[c] = (s >= 64'h1_0000_0000);
        m_acc[c]  = s % 64'h1_0000_0000;
        m_ph[c]   = m_ph[c] ^ m_tick[c];
      end else begin
        m_tick[c] = 1'b0; m_ph[c] = 1'b0;
      end
      if (sel) begin
        m_inc[c] = cfg_inc; m_en[c] = cfg_en;
      end
    end
    if (sw_rst) m_sb = 0;
    else if (sb_prev && m_sb < RC + NCH) m_sb++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    logic [3:0] e_tick, e_rst, e_ph;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = m_tick[i];
      e_rst[i]  = (m_sb >= RC + 1 + i);
      e_ph[i]   = m_ph[i];
    end
    chk("tick_o", {28'd0, tick_o}, {28'd0, e_tick});
    chk("rst_n_o", {28'd0, rst_n_o}, {28'd0, e_rst});
    chk("ready_o", {31'd0, ready_o}, {31'd0, (m_sb >= RC + NCH)});
`ifdef USB4_PHASE_OUT_EN
    chk("phase_o", {28'd0, phase_o}, {28'd0, e_ph});
`endif
  endtask

  task automatic step();
    @(posedge local_clk);
    model_edge();
    @(negedge local_clk);
    compare();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic en, input logic [31:0] inc);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_inc = inc;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held, then released with no configuration: SB stalls in HOLD.
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("stall_ready", {31'd0, ready_o}, 32'd0);

    // SB channel paces the sequence to RUN.
    cfg(2'd0, 1'b1, 32'h4000_0000);
    for (int k = 0; k < 40; k++) step();
    chk("run_ready", {31'd0, ready_o}, 32'd1);
    chk("run_rst_n", {28'd0, rst_n_o}, 32'hF);

    // Channel 1 rate change, disable and re-enable from cleared phase.
    cfg(2'd1, 1'b1, 32'h8000_0000);
    for (int k = 0; k < 9; k++) step();
    cfg(2'd1, 1'b1, 32'h2000_0000);
    for (int k = 0; k < 24; k++) step();
    cfg(2'd1, 1'b0, 32'h2000_0000);
    chk("ch1_off_tick", {31'd0, tick_o[1]}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    cfg(2'd1, 1'b1, 32'h6000_0000);
    for (int k = 0; k < 12; k++) step();

    // Randomized config traffic and occasional soft resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1; cfg_ch = 2'($urandom_range(1, 3));
        cfg_en = ($urandom_range(0, 3) != 0); cfg_inc = $urandom;
      end
      sw_rst = ($urandom_range(0, 49) == 0);
      step();
      cfg_we = 1'b0; sw_rst = 1'b0;
    end

    // Soft reset in RUN coinciding with an SB tick.
    for (int k = 0; k < 200 && !(m_sb == RC + NCH && m_tick[0]); k++) step();
    chk("reach_run_tick", {31'd0, (m_sb == RC + NCH && m_tick[0])}, 32'd1);
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    chk("swrst_ready", {31'd0, ready_o}, 32'd0);
    chk("swrst_rst_n", {28'd0, rst_n_o}, 32'd0);
    for (int k = 0; k < 100 && m_sb < RC + NCH; k++) step();
    chk("rerelease_ready", {31'd0, ready_o}, 32'd1);

    // Async reset with two channels released.
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    for (int k = 0; k < 200 && m_sb != RC + 2; k++) step();
    chk("two_released", {28'd0, rst_n_o}, 32'h3);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_tick", {28'd0, tick_o}, 32'd0);
    chk("arst_rst_n", {28'd0, rst_n_o}, 32'd0);
    chk("arst_ready", {31'd0, ready_o}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("arst_cfg_cleared", {28'd0, tick_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
